// File: rtl/ps2_keyboard_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx_pkg
//  Brief    : Shared types and constants for the PS/2 keyboard receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_keyboard_rx_pkg;

  // Width of the user_design stream word and of a PS/2 scan code.
  localparam int C_STREAM_W = 32;
  localparam int C_CODE_W   = 8;

  // Frame receiver states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the code bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [C_CODE_W-1:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_fifo
//  Brief    : Small synchronous scan-code FIFO with wrap-bit pointers.
//             A pop in the same cycle as a push into a full FIFO frees the
//             slot, so the push is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [7:0]  r_mem [DEPTH];
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = ((r_wr ^ r_rd) == {1'b1, {AW{1'b0}}});
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx
//  Brief    : PS/2 device-to-host receiver. Synchronises and glitch-filters
//             the pins, deserialises 11-bit frames, checks framing and odd
//             parity, buffers good codes and presents them on a stb/ack
//             stream.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [C_STREAM_W-1:0] output_ps2,
  output logic                  output_ps2_stb,
  input  logic                  output_ps2_ack,
  output logic                  frame_error,
  output logic                  overflow
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_q;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic          w_push, w_err;

  logic          r_frame_error, r_overflow;
  logic          w_full, w_empty, w_pop;
  logic [7:0]    w_head;

  // Pin synchronisers and clock glitch filter; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1     <= 1'b1;
      r_clk_s2     <= 1'b1;
      r_dat_s1     <= 1'b1;
      r_dat_s2     <= 1'b1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_q <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_s1     <= ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= ps2_data;
      r_dat_s2     <= r_dat_s1;
      r_clk_filt_q <= r_clk_filt;
      if (r_clk_s2 != r_clk_filt) begin
        if (r_filt_cnt == FW'(FILTER_CYCLES - 1)) begin
          r_clk_filt <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + FW'(1);
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_clk_filt_q & ~r_clk_filt;

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_parity      <= w_parity_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_frame_error <= w_err;
      r_overflow    <= w_push & w_full & ~w_pop;
    end
  end

  // Next-state logic: bits advance on filtered falling edges; a stalled frame times out.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_to_cnt_nxt  = '0;
    w_push        = 1'b0;
    w_err         = 1'b0;

    if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_parity_nxt = r_dat_s2;
          w_state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          if (r_dat_s2 && odd_parity_ok(r_shift, r_parity)) w_push = 1'b1;
          else                                               w_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        w_state_nxt = ST_IDLE;
        w_err       = 1'b1;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TW'(1);
      end
    end
  end

  assign w_pop = output_ps2_stb & output_ps2_ack;

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign output_ps2_stb = ~w_empty;
  assign output_ps2     = {{(C_STREAM_W - C_CODE_W){1'b0}}, w_head};
  assign frame_error    = r_frame_error;
  assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keyboard_rx
//  Brief    : Directed, table-driven bench for ps2_keyboard_rx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

  localparam int FILT    = 8;
  localparam int TMO     = 2000;
  localparam int DEPTH   = 4;
  localparam int HALF    = 40;
  localparam int SETTLE  = 30;

  logic        clk, rst, ps2_clk, ps2_data, ack;
  logic [31:0] output_ps2;
  logic        output_ps2_stb, frame_error, overflow;

  int total = 0;
  int bad   = 0;

  int          got_q[$];
  int          stb_cyc, err_n, ovf_n, unstable_n;
  logic [31:0] prev_word;
  logic        prev_hold;

  ps2_keyboard_rx #(
    .FILTER_CYCLES  (FILT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .output_ps2     (output_ps2),
    .output_ps2_stb (output_ps2_stb),
    .output_ps2_ack (ack),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream monitor sampled on the falling clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (output_ps2_stb && ack) got_q.push_back(int'(output_ps2));
      if (output_ps2_stb) stb_cyc++;
      if (frame_error) err_n++;
      if (overflow) ovf_n++;
      if (prev_hold && output_ps2_stb && output_ps2 != prev_word) unstable_n++;
      prev_hold = output_ps2_stb && !ack;
      prev_word = output_ps2;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    stb_cyc    = 0;
    err_n      = 0;
    ovf_n      = 0;
    unstable_n = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the first nedges bits of a frame; optional short glitches in each half-bit.
  task automatic send_frame(input logic [7:0] d, input logic flip, input int nedges, input logic glitch);
    logic [10:0] bits;
    int          ones;
    logic        par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    par  = par ^ flip;
    bits = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_clk(HALF / 2);
        ps2_clk = 1'b0; wait_clk(1); ps2_clk = 1'b1;
        wait_clk(HALF - HALF / 2 - 1);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b0;
      if (glitch) begin
        wait_clk(HALF / 2);
        ps2_clk = 1'b1; wait_clk(5); ps2_clk = 1'b0;
        wait_clk(HALF - HALF / 2 - 5);
      end else begin
        wait_clk(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] code;
    logic       flip;
    logic       glitch;
    int         exp_n;
    int         exp_word;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{code: 8'h1C, flip: 1'b0, glitch: 1'b0, exp_n: 1, exp_word: 32'h1C, exp_err: 0};
    vecs[1] = '{code: 8'h1C, flip: 1'b1, glitch: 1'b0, exp_n: 0, exp_word: 0,      exp_err: 1};
    vecs[2] = '{code: 8'hF0, flip: 1'b0, glitch: 1'b1, exp_n: 1, exp_word: 32'hF0, exp_err: 0};
    vecs[3] = '{code: 8'h5A, flip: 1'b0, glitch: 1'b1, exp_n: 1, exp_word: 32'h5A, exp_err: 0};
    vecs[4] = '{code: 8'h00, flip: 1'b0, glitch: 1'b0, exp_n: 1, exp_word: 0,      exp_err: 0};
    vecs[5] = '{code: 8'hFF, flip: 1'b1, glitch: 1'b0, exp_n: 0, exp_word: 0,      exp_err: 1};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ack = 1'b0;
    prev_word = '0; prev_hold = 1'b0;
    clear_mon();
    wait_clk(5);
    chk("reset_data", output_ps2, 32'h0);
    chk("reset_stb", {31'b0, output_ps2_stb}, 32'h0);
    chk("reset_ferr", {31'b0, frame_error}, 32'h0);
    chk("reset_ovf", {31'b0, overflow}, 32'h0);
    rst = 1'b0;
    wait_clk(5);

    // Single frames with ack held high.
    ack = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].code, vecs[v].flip, 11, vecs[v].glitch);
      wait_clk(SETTLE);
      chk($sformatf("v%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
      chk($sformatf("v%0d_word", v), (got_q.size() > 0) ? 32'(got_q[0]) : 32'h0, 32'(vecs[v].exp_word));
      chk($sformatf("v%0d_stbcyc", v), 32'(stb_cyc), 32'(vecs[v].exp_n));
      chk($sformatf("v%0d_ferr", v), 32'(err_n), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_ovf", v), 32'(ovf_n), 32'h0);
    end

    // Partial frame then silence: timeout error, then a clean frame.
    clear_mon();
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    wait_clk(TMO - 100);
    chk("tmo_early", 32'(err_n), 32'h0);
    wait_clk(300);
    chk("tmo_fired", 32'(err_n), 32'h1);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    wait_clk(SETTLE);
    chk("tmo_next_count", 32'(got_q.size()), 32'h1);
    chk("tmo_next_word", (got_q.size() > 0) ? 32'(got_q[0]) : 32'h0, 32'hF0);
    chk("tmo_next_ferr", 32'(err_n), 32'h1);

    // Fill the FIFO with ack low; fifth code overflows.
    ack = 1'b0;
    clear_mon();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b0, 11, 1'b0);
      wait_clk(SETTLE);
    end
    chk("ovf_pulses", 32'(ovf_n), 32'h1);
    chk("ovf_ferr", 32'(err_n), 32'h0);
    chk("ovf_hold_stb", {31'b0, output_ps2_stb}, 32'h1);
    chk("ovf_hold_word", output_ps2, 32'h1);
    chk("ovf_stable", 32'(unstable_n), 32'h0);
    ack = 1'b1;
    wait_clk(10);
    chk("drain_count", 32'(got_q.size()), 32'h4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain_%0d", k), (got_q.size() > k) ? 32'(got_q[k]) : 32'hDEAD, 32'(k + 1));
    chk("drain_stb", {31'b0, output_ps2_stb}, 32'h0);
    chk("drain_ovf", 32'(ovf_n), 32'h1);

    // Reset in the middle of a frame discards it silently.
    clear_mon();
    send_frame(8'h1C, 1'b0, 5, 1'b0);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    wait_clk(SETTLE);
    chk("rstmid_count", 32'(got_q.size()), 32'h1);
    chk("rstmid_word", (got_q.size() > 0) ? 32'(got_q[0]) : 32'h0, 32'h1C);
    chk("rstmid_ferr", 32'(err_n), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
